// File: rtl/id_stage_pipe.sv
// Decode stage: IF/ID register, 2R1W register file, operand forwarding/bypass,
// load-use stall and branch/jump resolution in ID. `define ID_FWD_EN enables EX/MEM forwarding.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    // fetch handshake
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [DATA_W-1:0] if_pc_4,
    input  logic [31:0]       if_instr,
    // decode to EX
    output logic              id_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] id_pc_4,
    output logic [31:0]       id_instr,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [DATA_W-1:0] id_imm,
    output logic [AW-1:0]     id_wr_addr,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    // EX producer
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [AW-1:0]     ex_wr_addr,
    input  logic [DATA_W-1:0] ex_alu_out,
    // MEM producer
    input  logic              mem_wr_en,
    input  logic              mem_is_load,
    input  logic [AW-1:0]     mem_wr_addr,
    input  logic [DATA_W-1:0] mem_alu_out,
    input  logic [DATA_W-1:0] mem_rdata,
    // write-back
    input  logic              wb_wr_en,
    input  logic [AW-1:0]     wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    output logic              stall
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [AW-1:0] LINK_REG = AW'(31);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] rf_q [NREG];

    logic [5:0]              op, funct;
    logic [AW-1:0]           rs_a, rt_a, rd_a;
    logic [1:0][AW-1:0]      src_a;
    logic [1:0][DATA_W-1:0]  src_d;
    logic [1:0]              src_haz;
    logic                    id_fire, taken, imm_zx;
    logic [DATA_W-1:0]       imm_sx, br_off;

    assign op    = instr_q[31:26];
    assign funct = instr_q[5:0];
    assign rs_a  = instr_q[21 +: AW];
    assign rt_a  = instr_q[16 +: AW];
    assign rd_a  = instr_q[11 +: AW];
    assign src_a = {rt_a, rs_a};

    // Operand selection: later assignments win, so priority is EX > MEM > WB > file.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src_d[i]   = (src_a[i] == '0) ? '0 : rf_q[src_a[i]];
            src_haz[i] = 1'b0;
            if (src_a[i] != '0) begin
                if (wb_wr_en && wb_wr_addr == src_a[i]) src_d[i] = wb_wr_data;
`ifdef ID_FWD_EN
                if (mem_wr_en && mem_wr_addr == src_a[i])
                    src_d[i] = mem_is_load ? mem_rdata : mem_alu_out;
                if (ex_wr_en && !ex_is_load && ex_wr_addr == src_a[i]) src_d[i] = ex_alu_out;
                src_haz[i] = ex_wr_en && ex_is_load && (ex_wr_addr == src_a[i]);
`else
                src_haz[i] = (ex_wr_en && ex_wr_addr == src_a[i]) ||
                             (mem_wr_en && mem_wr_addr == src_a[i]);
`endif
            end
        end
    end

`ifndef ID_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load, ex_alu_out, mem_is_load, mem_alu_out, mem_rdata};
`endif

    assign stall    = valid_q && (|src_haz);
    assign id_valid = valid_q && !stall;
    assign id_fire  = id_valid && ex_ready;
    assign if_ready = !valid_q || id_fire;

    assign imm_zx = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    assign imm_sx = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
    assign id_imm = imm_zx ? {{(DATA_W-16){1'b0}}, instr_q[15:0]} : imm_sx;
    assign br_off = {imm_sx[DATA_W-3:0], 2'b00};

    assign id_wr_addr = (op == OP_JAL) ? LINK_REG : ((op != OP_RTYPE) ? rt_a : rd_a);
    // JAL hands EX pc_4 + 0 so the ALU produces the link value.
    assign id_rs_data = (op == OP_JAL) ? pc4_q : src_d[0];
    assign id_rt_data = (op == OP_JAL) ? '0 : src_d[1];
    assign id_pc_4    = pc4_q;
    assign id_instr   = instr_q;

    always_comb begin
        taken       = 1'b0;
        redirect_pc = pc4_q + br_off;
        case (op)
            OP_BEQ: taken = (src_d[0] == src_d[1]);
            OP_BNE: taken = (src_d[0] != src_d[1]);
            OP_J, OP_JAL: begin
                taken       = 1'b1;
                redirect_pc = {pc4_q[DATA_W-1:28], instr_q[25:0], 2'b00};
            end
            OP_RTYPE: begin
                if (funct == F_JR) begin
                    taken       = 1'b1;
                    redirect_pc = src_d[0];
                end
            end
            default: ;
        endcase
    end

    assign redirect = id_fire && taken;

    // A taken redirect squashes whatever fetch is presenting this cycle.
    always_comb begin
        valid_d = valid_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        if (redirect) begin
            valid_d = 1'b0;
        end else if (if_valid && if_ready) begin
            valid_d = 1'b1;
            pc4_d   = if_pc_4;
            instr_d = if_instr;
        end else if (id_fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc4_q   <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_wr_en && wb_wr_addr != '0) begin
            rf_q[wb_wr_addr] <= wb_wr_data;
        end
    end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter DATA_W, 32, datapath/PC width; legal values 32 and 64.
REQ-002 Parameter NREG, 32, architectural register count; power of two; AW=log2(NREG) SHALL size register address ports.
REQ-003 clk  in  1  rising-edge clock; the block SHALL use one clock; reset is synchronous and active-high.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 if_valid / if_ready  in / out  1 / 1  fetch handshake; if_pc_4 in DATA_W, if_instr in 32.
REQ-006 id_valid out 1, ex_ready in 1  decode-to-EX handshake; id_pc_4 out DATA_W, id_instr out 32.
REQ-007 id_rs_data / id_rt_data  out  DATA_W  forwarded operands; id_imm out DATA_W; id_wr_addr out AW.
REQ-008 redirect out 1, redirect_pc out DATA_W  fetch redirect for taken branch/jump.
REQ-009 ex_wr_en, ex_is_load in 1; ex_wr_addr in AW; ex_alu_out in DATA_W  EX-stage producer.
REQ-010 mem_wr_en, mem_is_load in 1; mem_wr_addr in AW; mem_alu_out, mem_rdata in DATA_W  MEM-stage producer.
REQ-011 wb_wr_en in 1, wb_wr_addr in AW, wb_wr_data in DATA_W  register-file write port; stall out 1.

Function
REQ-012 IF/ID register (valid bit, pc_4, instr) SHALL load on if_valid && if_ready; contents drive id_* one cycle later.
REQ-013 id_fire = id_valid && ex_ready && !stall; if_ready = !held_valid || id_fire; hold contents when occupied and not firing.
REQ-014 Register file: NREG x DATA_W, two combinational reads (rs=instr[25:21], rt=instr[20:16] truncated to AW), one synchronous write; register 0 SHALL read 0 and ignore writes.
REQ-015 Same-cycle WB write and read of same nonzero register SHALL return wb_wr_data.
REQ-016 Forward priority per operand: EX alu_out (ex_wr_en, !ex_is_load, addr match) > MEM (mem_is_load ? mem_rdata : mem_alu_out) > WB bypass > file; address 0 never forwards.
REQ-017 stall SHALL assert when id_valid and rs or rt (nonzero) matches ex_wr_addr with ex_wr_en && ex_is_load; id_valid SHALL be 0 to EX while stalled (bubble).
REQ-018 id_imm: zero-extend instr[15:0] for opcodes 0x0C/0x0D/0x0E, else sign-extend to DATA_W.
REQ-019 id_wr_addr: 31 for JAL (0x03); rt for I-type (opcode != 0); rd for R-type.
REQ-020 Branch/jump resolved in ID on id_fire: BEQ(0x04) rs==rt, BNE(0x05) rs!=rt -> pc_4+(sext imm<<2); J/JAL -> {pc_4[DATA_W-1:28], instr[25:0], 2'b00}; JR (op 0, funct 0x08) -> rs_data.
REQ-021 redirect SHALL be combinational, high only in the id_fire cycle of a taken control instruction; same cycle the IF/ID register SHALL clear valid and discard any concurrent fetch capture (no delay slot).
REQ-022 JAL SHALL present id_rs_data=pc_4 and id_rt_data=0 so EX computes link value.
REQ-023 stall and redirect SHALL never both assert; redirect requires !stall.

Reset
REQ-024 On rst: IF/ID valid=0, instr=0 (NOP), pc_4=0; all registers of the file = 0; outputs id_valid=0, redirect=0, stall=0, if_ready=1.
REQ-025 rst mid-stall or mid-redirect SHALL take priority; no write-back occurs in the reset cycle.

Configuration
REQ-026 Macro ID_FWD_EN defined: forwarding per REQ-016, stall only per REQ-017.
REQ-027 ID_FWD_EN undefined: no EX/MEM forwarding; stall SHALL assert for any nonzero rs/rt match with a writing EX or MEM producer; WB bypass retained.

Verification
REQ-028 add r3 in EX (ex_alu_out=0x55), ID reads r3 -> id_rs_data=0x55, stall=0 (ID_FWD_EN).
REQ-029 lw r4 in EX, ID uses r4 -> stall=1 one cycle, id_valid=0, if_ready=0; next cycle mem_rdata=0x1234 forwarded, stall=0.
REQ-030 beq r1,r2 equal, pc_4=0x100, imm=0xFFFF -> redirect=1, redirect_pc=0xFC, next id_valid=0.
REQ-031 WB write r7=0xA5 same cycle ID reads r7 -> id_rt_data=0xA5; write to r0 -> reads 0.
REQ-032 ex_ready=0 for 3 cycles with valid instr -> id_* stable, if_ready=0; ori imm 0x8000 -> id_imm=0x00008000.
REQ-033 rst asserted during stall -> next cycle id_valid=0, stall=0, if_ready=1.
